// File: rtl/traffic_pkg.sv
// Shared phase codes, lamp encodings, converter states and 7-segment lookup
// for the traffic-light lane display logic.
package traffic_pkg;

  localparam logic [2:0] GR = 3'd3;
  localparam logic [2:0] YR = 3'd4;
  localparam logic [2:0] RG = 3'd5;
  localparam logic [2:0] RY = 3'd6;

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  typedef enum logic [1:0] {
    CNV_LOAD  = 2'd0,
    CNV_SHIFT = 2'd1,
    CNV_STORE = 2'd2
  } cnv_state_t;

  // Active-low {g,f,e,d,c,b,a}; non-decimal codes blank the digit.
  function automatic logic [6:0] seg7(input logic [3:0] digit);
    case (digit)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 converter: 7-bit binary (0..99) to two BCD digits,
// one LOAD cycle, seven SHIFT cycles and one STORE cycle with a done pulse.
module bin2bcd_seq
  import traffic_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [6:0] bin,
  output logic       done,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  cnv_state_t  state_reg, state_next;
  logic [7:0]  bcd_reg, bcd_next;
  logic [6:0]  shift_reg, shift_next;
  logic [2:0]  cnt_reg, cnt_next;
  logic [7:0]  bcd_adj;
  logic [14:0] shifted;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= CNV_LOAD;
      bcd_reg   <= '0;
      shift_reg <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      bcd_reg   <= bcd_next;
      shift_reg <= shift_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    bcd_next     = bcd_reg;
    shift_next   = shift_reg;
    cnt_next     = cnt_reg;
    done         = 1'b0;
    bcd_adj[7:4] = (bcd_reg[7:4] >= 4'd5) ? bcd_reg[7:4] + 4'd3 : bcd_reg[7:4];
    bcd_adj[3:0] = (bcd_reg[3:0] >= 4'd5) ? bcd_reg[3:0] + 4'd3 : bcd_reg[3:0];
    shifted      = {bcd_adj, shift_reg} << 1;
    case (state_reg)
      CNV_LOAD: begin
        if (start) begin
          shift_next = bin;
          bcd_next   = '0;
          cnt_next   = '0;
          state_next = CNV_SHIFT;
        end
      end
      CNV_SHIFT: begin
        bcd_next   = shifted[14:7];
        shift_next = shifted[6:0];
        cnt_next   = cnt_reg + 3'd1;
        if (cnt_reg == 3'd6) state_next = CNV_STORE;
      end
      CNV_STORE: begin
        done       = 1'b1;
        state_next = CNV_LOAD;
      end
      default: state_next = CNV_LOAD;
    endcase
  end

  assign tens = bcd_reg[7:4];
  assign ones = bcd_reg[3:0];

endmodule

// File: rtl/lane_display_driver.sv
// Lamp decode for both lanes plus a 4-digit multiplexed countdown display,
// fed by one BCD converter shared round-robin between the two lanes.
module lane_display_driver
  import traffic_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [2:0] state,
  input  logic [6:0] timeLane1,
  input  logic [6:0] timeLane2,
  output logic [2:0] lamp1,
  output logic [2:0] lamp2,
  output logic [6:0] seg,
  output logic [3:0] an
);

  localparam int SCAN_W  = $clog2(SCAN_DIV);
  localparam int BLINK_W = $clog2(BLINK_DIV);
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  logic               lane_sel_reg;
  logic [6:0]         lane_raw, lane_clamped;
  logic               conv_done;
  logic [3:0]         conv_tens, conv_ones;
  logic [3:0]         digit_reg [4];
  logic [SCAN_W-1:0]  scan_cnt_reg;
  logic [1:0]         scan_idx_reg;
  logic [BLINK_W-1:0] blink_cnt_reg;
  logic               blink_reg;
  logic [3:0]         scan_digit;
  logic               blank;
  logic [3:0]         an_next;
  logic [6:0]         seg_next;
  logic [2:0]         flash, lamp1_next, lamp2_next;

  assign lane_raw     = lane_sel_reg ? timeLane2 : timeLane1;
  assign lane_clamped = (lane_raw > 7'd99) ? 7'd99 : lane_raw;

  bin2bcd_seq u_bcd (
    .clk   (clk),
    .reset (reset),
    .start (1'b1),
    .bin   (lane_clamped),
    .done  (conv_done),
    .tens  (conv_tens),
    .ones  (conv_ones)
  );

  // Digit slots: 0=lane-1 ones, 1=lane-1 tens, 2=lane-2 ones, 3=lane-2 tens.
  assign scan_digit = digit_reg[scan_idx_reg];
  assign blank      = !enable || (scan_idx_reg[0] && (scan_digit == 4'd0));
  assign seg_next   = blank ? 7'h7F : seg7(scan_digit);

  always_comb begin
    an_next = 4'hF;
    if (!blank) an_next[scan_idx_reg] = 1'b0;
  end

  always_comb begin
    flash      = {1'b0, blink_reg, 1'b0};
    lamp1_next = flash;
    lamp2_next = flash;
    if (enable) begin
      case (state)
        GR: begin lamp1_next = LAMP_G; lamp2_next = LAMP_R; end
        YR: begin lamp1_next = LAMP_Y; lamp2_next = LAMP_R; end
        RG: begin lamp1_next = LAMP_R; lamp2_next = LAMP_G; end
        RY: begin lamp1_next = LAMP_R; lamp2_next = LAMP_Y; end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lane_sel_reg  <= 1'b0;
      for (int i = 0; i < 4; i++) digit_reg[i] <= '0;
      scan_cnt_reg  <= '0;
      scan_idx_reg  <= '0;
      blink_cnt_reg <= '0;
      blink_reg     <= 1'b0;
      lamp1         <= 3'b000;
      lamp2         <= 3'b000;
      seg           <= 7'h7F;
      an            <= 4'hF;
    end else begin
      // Both digits of a lane update in the same cycle, only from a finished conversion.
      if (conv_done) begin
        digit_reg[{lane_sel_reg, 1'b0}] <= conv_ones;
        digit_reg[{lane_sel_reg, 1'b1}] <= conv_tens;
        lane_sel_reg <= ~lane_sel_reg;
      end
      if (scan_cnt_reg == SCAN_LAST) begin
        scan_cnt_reg <= '0;
        scan_idx_reg <= scan_idx_reg + 2'd1;
      end else begin
        scan_cnt_reg <= scan_cnt_reg + 1'b1;
      end
      if (blink_cnt_reg == BLINK_LAST) begin
        blink_cnt_reg <= '0;
        blink_reg     <= ~blink_reg;
      end else begin
        blink_cnt_reg <= blink_cnt_reg + 1'b1;
      end
      lamp1 <= lamp1_next;
      lamp2 <= lamp2_next;
      seg   <= seg_next;
      an    <= an_next;
    end
  end

endmodule
